// File: rtl/is_prime_pkg.sv
// is_prime shared package: constant helpers and FSM state type.
// Used by the sieve top and its lane clear-mask generator.
package is_prime_pkg;

    typedef enum logic [1:0] {
        S_SEEK,
        S_CLEAR,
        S_DONE
    } state_t;

    // Ceiling log2, never less than 1 so every derived width is legal.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Floor of the integer square root.
    function automatic int isqrt(input int n);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/is_prime_clear_lanes.sv
// is_prime_clear_lanes: one-cycle clear masks for LANES multiples of d.
// Ports: m, d in; res_mask (result bits), dfl_mask (divisor flags) out.
module is_prime_clear_lanes
    import is_prime_pkg::*;
#(
    parameter int OUT_WIDTH = 10000,
    parameter int START     = 10,
    parameter int LANES     = 4,
    localparam int MAXV     = START + OUT_WIDTH - 1,
    localparam int SQRT_MAX = isqrt(MAXV),
    localparam int DW0      = clog2(SQRT_MAX + 2),
    localparam int DW       = (DW0 < 2) ? 2 : DW0,
    localparam int MW       = clog2(MAXV + LANES * SQRT_MAX + 1),
    localparam int RW       = clog2(OUT_WIDTH)
) (
    input  logic [MW-1:0]        m,
    input  logic [DW-1:0]        d,
    output logic [OUT_WIDTH-1:0] res_mask,
    output logic [SQRT_MAX+1:0]  dfl_mask
);

    always_comb begin
        int v;
        v = 0;
        res_mask = '0;
        dfl_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            v = int'(m) + k * int'(d);
            if (v <= MAXV) begin
                if (v >= START)
                    res_mask[RW'(v - START)] = 1'b1;
                if (v <= SQRT_MAX)
                    dfl_mask[DW'(v)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/is_prime.sv
// is_prime: autonomous Sieve of Eratosthenes over [START, START+OUT_WIDTH-1].
// Ports: clk; rst_n (async, active-high); result (bit i = START+i prime); done.
module is_prime
    import is_prime_pkg::*;
#(
    parameter int OUT_WIDTH = 10000,
    parameter int START     = 10,
    parameter int LANES     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 done
);

    localparam int MAXV     = START + OUT_WIDTH - 1;
    localparam int SQRT_MAX = isqrt(MAXV);
    localparam int DW0      = clog2(SQRT_MAX + 2);
    localparam int DW       = (DW0 < 2) ? 2 : DW0;
    localparam int MW       = clog2(MAXV + LANES * SQRT_MAX + 1);

    state_t                state;
    logic [DW-1:0]         d;
    logic [MW-1:0]         m;
    logic [SQRT_MAX+1:0]   dflag;
    logic [OUT_WIDTH-1:0]  res_mask;
    logic [SQRT_MAX+1:0]   dfl_mask;
    logic [MW-1:0]         dd;
    logic [MW-1:0]         m_nxt;
    logic                  last;

    is_prime_clear_lanes #(
        .OUT_WIDTH (OUT_WIDTH),
        .START     (START),
        .LANES     (LANES)
    ) u_lanes (
        .m        (m),
        .d        (d),
        .res_mask (res_mask),
        .dfl_mask (dfl_mask)
    );

    // Step and wrap test done in int so the compare sees the true sum.
    always_comb begin
        int sum;
        sum   = int'(m) + LANES * int'(d);
        m_nxt = MW'(sum);
        last  = (sum > MAXV);
        dd    = MW'(int'(d) * int'(d));
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < OUT_WIDTH; i++)
                result[i] <= (START + i >= 2);
            for (int i = 0; i < SQRT_MAX + 2; i++)
                dflag[i] <= (i >= 2);
            done  <= 1'b0;
            d     <= DW'(2);
            m     <= '0;
            state <= S_SEEK;
        end else begin
            unique case (state)
                S_SEEK: begin
                    if (int'(d) > SQRT_MAX) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (dflag[d]) begin
                        // Smaller multiples were already cleared by smaller primes.
                        m     <= dd;
                        state <= S_CLEAR;
                    end else begin
                        d <= d + 1'b1;
                    end
                end
                S_CLEAR: begin
                    result <= result & ~res_mask;
                    dflag  <= dflag & ~dfl_mask;
                    m      <= m_nxt;
                    if (last) begin
                        d     <= d + 1'b1;
                        state <= S_SEEK;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= S_SEEK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_is_prime.sv
// Bench for is_prime: trial-division model, scoreboard on done rising.
// Default instance plus a 32-bit START=0 LANES=1 instance share the reset.
module tb_is_prime;

    localparam int W  = 10000;
    localparam int S  = 10;
    localparam int L  = 4;
    localparam int WS = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  res;
    logic          done;
    logic [WS-1:0] res_s;
    logic          done_s;

    always #5 clk = ~clk;

    is_prime #(.OUT_WIDTH(W), .START(S), .LANES(L)) dut (
        .clk    (clk),
        .rst_n  (rst),
        .result (res),
        .done   (done)
    );

    is_prime #(.OUT_WIDTH(WS), .START(0), .LANES(1)) dut_s (
        .clk    (clk),
        .rst_n  (rst),
        .result (res_s),
        .done   (done_s)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  exp_big;
    logic [W-1:0]  rst_big;
    logic [WS-1:0] exp_s;
    logic [WS-1:0] rst_s;

    logic [W-1:0]  sb_q[$];
    logic [WS-1:0] sbs_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    function automatic bit is_p(input int n);
        if (n < 2)
            return 1'b0;
        for (int k = 2; k * k <= n; k++)
            if (n % k == 0)
                return 1'b0;
        return 1'b1;
    endfunction

    // Scoreboard monitors: compare whenever an instance raises done.
    logic done_q   = 1'b0;
    logic done_s_q = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (done && !done_q) begin
            if (sb_q.size() == 0) begin
                chk("sb_big_unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_big_bit_diffs", $countones(res ^ e), 0);
            end
        end
        done_q <= done;
    end

    always @(negedge clk) begin
        logic [WS-1:0] e;
        if (done_s && !done_s_q) begin
            if (sbs_q.size() == 0) begin
                chk("sb_small_unexpected_done", 1, 0);
            end else begin
                e = sbs_q.pop_front();
                chk("sb_small_result", res_s, e);
            end
        end
        done_s_q <= done_s;
    end

    task automatic check_reset(input string tag);
        chk({tag, "_rst_big_diffs"}, $countones(res ^ rst_big), 0);
        chk({tag, "_rst_done"}, done, 0);
        chk({tag, "_rst_small"}, res_s, rst_s);
        chk({tag, "_rst_done_s"}, done_s, 0);
    endtask

    task automatic release_run(input bit big_completes);
        @(negedge clk);
        rst = 1'b0;
        sbs_q.push_back(exp_s);
        if (big_completes)
            sb_q.push_back(exp_big);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_within_10000"}, done, 1);
    endtask

    task automatic abort_at(input int cyc, input string tag);
        repeat (cyc) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset(tag);
    endtask

    initial begin
        int n_abort;
        bit stable;

        for (int i = 0; i < W; i++) begin
            exp_big[i] = is_p(S + i);
            rst_big[i] = (S + i >= 2);
        end
        for (int i = 0; i < WS; i++) begin
            exp_s[i] = is_p(i);
            rst_s[i] = (i >= 2);
        end

        #12 check_reset("init");

        release_run(1'b1);
        wait_done("run1");

        chk("r1_bit1_11", res[1], 1);
        chk("r1_bit3_13", res[3], 1);
        chk("r1_bit7_17", res[7], 1);
        chk("r1_bit9_19", res[9], 1);
        chk("r1_bit0_10", res[0], 0);
        chk("r1_bit2_12", res[2], 0);
        chk("r1_bit5_15", res[5], 0);
        chk("r1_popcount", $countones(res), 1227);
        chk("r1_bit9963_9973", res[9963], 1);
        chk("r1_bit9997_10007", res[9997], 1);
        chk("r1_bit9999_10009", res[9999], 1);
        chk("r1_bit9990_10000", res[9990], 0);
        chk("r1_bit9399_9409", res[9399], 0);
        chk("r1_bit111_121", res[111], 0);
        chk("r1_small_const", res_s, 32'hA08A28AC);
        chk("r1_small_done", done_s, 1);

        stable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (!done || res !== exp_big || !done_s || res_s !== exp_s)
                stable = 1'b0;
        end
        chk("r1_hold_100", stable, 1);

        // Abort at cycle 500, then a full rerun.
        rst = 1'b1;
        #3 check_reset("rst2");
        release_run(1'b0);
        abort_at(500, "abort500");
        release_run(1'b1);
        wait_done("rerun");
        chk("rerun_bit_diffs", $countones(res ^ exp_big), 0);

        // Random abort point, then a full rerun.
        n_abort = $urandom_range(4000, 100);
        rst = 1'b1;
        #3 check_reset("rst3");
        release_run(1'b0);
        abort_at(n_abort, "abort_rand");
        release_run(1'b1);
        wait_done("rerun2");
        chk("rerun2_popcount", $countones(res), 1227);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size() + sbs_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
